// File: rtl/fifo_sched_pkg.sv
// Shared constants and state encodings for the FIFO bank and its pop scheduler.
package fifo_sched_pkg;

    localparam int DATA_W    = 6;
    localparam int THR_W     = 2;
    localparam int FULL_DEF  = 3;
    localparam int EMPTY_DEF = 1;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

endpackage

// File: rtl/fifo_pop_sched_rr_arbiter.sv
// Stateless round-robin arbiter: first requester at or above ptr_i (modulo N) wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic          enable_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] sel_o,
    output logic [IW-1:0] next_ptr_o
);

    logic          found;
    logic [IW-1:0] idx;

    // N is a power of two, so the IW-bit sum wraps modulo N for free.
    always_comb begin
        grant_o    = '0;
        sel_o      = '0;
        next_ptr_o = ptr_i;
        found      = 1'b0;
        idx        = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr_i + IW'(k);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                if (enable_i) begin
                    grant_o[idx] = 1'b1;
                    sel_o        = idx;
                    next_ptr_o   = idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_pop_sched.sv
// Pop scheduler and threshold controller for the FIFO bank: sequences
// RESET/INIT/IDLE/ACTIVE/ERROR and grants one round-robin pop per cycle.
module fifo_pop_sched #(
    parameter int NFIFO     = 4,
    parameter int THR_W     = fifo_sched_pkg::THR_W,
    parameter int FULL_DEF  = fifo_sched_pkg::FULL_DEF,
    parameter int EMPTY_DEF = fifo_sched_pkg::EMPTY_DEF,
    parameter int SEL_W     = $clog2(NFIFO)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [THR_W-1:0] umbral_full_in,
    input  logic [THR_W-1:0] umbral_empty_in,
    input  logic [NFIFO-1:0] fifo_empty,
    input  logic [NFIFO-1:0] fifo_error,
    input  logic             down_almost_full,
    output logic [NFIFO-1:0] pop,
    output logic [SEL_W-1:0] sel,
    output logic [THR_W-1:0] umbral_full,
    output logic [THR_W-1:0] umbral_empty,
    output logic [2:0]       state,
    output logic             idle_out,
    output logic             active_out,
    output logic             error_out
);

    import fifo_sched_pkg::*;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [THR_W-1:0]   full_q, full_d;
    logic [THR_W-1:0]   empty_q, empty_d;
    logic [SEL_W-1:0]   next_ptr;
    logic               grant_en;

    // Handshake: pop[i] is a single-cycle strobe; FIFO i is popped on every
    // rising edge where it is high. down_almost_full is the inverted ready of
    // the shared output path and suppresses pop in the same cycle.
    assign grant_en = (state_q == ST_ACTIVE) && !down_almost_full;

    rr_arbiter #(
        .N  (NFIFO),
        .IW (SEL_W)
    ) u_arb (
        .req_i      (~fifo_empty),
        .enable_i   (grant_en),
        .ptr_i      (ptr_q),
        .grant_o    (pop),
        .sel_o      (sel),
        .next_ptr_o (next_ptr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
            ptr_q   <= '0;
            full_q  <= THR_W'(FULL_DEF);
            empty_q <= THR_W'(EMPTY_DEF);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_comb begin
        state_d = state_q;
        full_d  = full_q;
        empty_d = empty_q;
        ptr_d   = (|pop) ? next_ptr : ptr_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                full_d  = umbral_full_in;
                empty_d = umbral_empty_in;
                if (!init) begin
                    state_d = (umbral_full_in > umbral_empty_in) ? ST_IDLE : ST_ERROR;
                end
            end
            ST_IDLE: begin
                if (init) begin
                    state_d = ST_INIT;
                end else if (!(&fifo_empty)) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (&fifo_empty) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
        // A FIFO error overrides every other transition once out of RESET.
        if ((state_q != ST_RESET) && (|fifo_error)) begin
            state_d = ST_ERROR;
        end
    end

    assign umbral_full  = full_q;
    assign umbral_empty = empty_q;
    assign state        = state_q;
    assign idle_out     = (state_q == ST_IDLE);
    assign active_out   = (state_q == ST_ACTIVE);
    assign error_out    = (state_q == ST_ERROR);

endmodule

// File: tb/tb_fifo_pop_sched.sv
// Directed bench for fifo_pop_sched: sequencing, thresholds, round-robin order,
// backpressure, wrap, error entry and asynchronous reset.
module tb_fifo_pop_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [1:0] full_in;
    logic [1:0] empty_in;
    logic [3:0] fifo_empty;
    logic [3:0] fifo_error;
    logic       daf;

    logic [3:0] pop;
    logic [1:0] sel;
    logic [1:0] umbral_full;
    logic [1:0] umbral_empty;
    logic [2:0] state;
    logic       idle_out;
    logic       active_out;
    logic       error_out;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_sel;

    fifo_pop_sched #(
        .NFIFO     (4),
        .THR_W     (2),
        .FULL_DEF  (3),
        .EMPTY_DEF (1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .init             (init),
        .umbral_full_in   (full_in),
        .umbral_empty_in  (empty_in),
        .fifo_empty       (fifo_empty),
        .fifo_error       (fifo_error),
        .down_almost_full (daf),
        .pop              (pop),
        .sel              (sel),
        .umbral_full      (umbral_full),
        .umbral_empty     (umbral_empty),
        .state            (state),
        .idle_out         (idle_out),
        .active_out       (active_out),
        .error_out        (error_out)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go_active();
        tick();
        reset      = 1'b0;
        init       = 1'b0;
        full_in    = 2'd3;
        empty_in   = 2'd1;
        fifo_error = 4'b0000;
        fifo_empty = 4'b0000;
        tick();
        tick();
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        init       = 1'b1;
        full_in    = 2'd2;
        empty_in   = 2'd0;
        fifo_empty = 4'hF;
        fifo_error = 4'h0;
        daf        = 1'b0;
        #3;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ufull", 32'(umbral_full), 32'd3);
        chk("rst_uempty", 32'(umbral_empty), 32'd1);
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_flags", 32'({idle_out, active_out, error_out}), 32'd0);

        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("init_enter", 32'(state), 32'd1);
        chk("init_noload_reset_edge", 32'(umbral_full), 32'd3);
        tick();
        chk("init_held", 32'(state), 32'd1);
        chk("init_load_full", 32'(umbral_full), 32'd2);
        chk("init_load_empty", 32'(umbral_empty), 32'd0);
        chk("init_pop", 32'(pop), 32'd0);

        full_in  = 2'd3;
        empty_in = 2'd1;
        init     = 1'b0;
        tick();
        chk("idle_state", 32'(state), 32'd2);
        chk("idle_out", 32'(idle_out), 32'd1);
        chk("idle_ufull", 32'(umbral_full), 32'd3);
        chk("idle_uempty", 32'(umbral_empty), 32'd1);
        tick();
        chk("idle_stay_empty", 32'(state), 32'd2);

        fifo_empty = 4'b0000;
        #1;
        chk("idle_no_pop", 32'(pop), 32'd0);
        tick();
        chk("active_state", 32'(state), 32'd3);
        chk("active_out", 32'(active_out), 32'd1);

        exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        while (exp_q.size() > 0) begin
            exp_sel = exp_q.pop_front();
            chk("rr_sel", 32'(sel), 32'(exp_sel));
            chk("rr_pop", 32'(pop), 32'(4'b0001 << exp_sel));
            tick();
        end

        daf = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_pop", 32'(pop), 32'd0);
            chk("bp_sel", 32'(sel), 32'd0);
            tick();
        end
        daf = 1'b0;
        #1;
        chk("bp_resume_sel", 32'(sel), 32'd1);
        chk("bp_resume_pop", 32'(pop), 32'b0010);
        tick();
        chk("bp_next_sel", 32'(sel), 32'd2);
        tick();

        fifo_empty = 4'b1011;
        #1;
        chk("wrap_pop", 32'(pop), 32'b0100);
        chk("wrap_sel", 32'(sel), 32'd2);
        tick();
        fifo_empty = 4'b0110;
        #1;
        chk("wrap_ptr3_sel", 32'(sel), 32'd3);
        chk("wrap_ptr3_pop", 32'(pop), 32'b1000);
        tick();
        fifo_empty = 4'b1011;
        #1;
        chk("wrap_from0_sel", 32'(sel), 32'd2);
        tick();
        fifo_empty = 4'hF;
        #1;
        chk("drain_pop", 32'(pop), 32'd0);
        chk("drain_state", 32'(state), 32'd3);
        tick();
        chk("drain_idle", 32'(state), 32'd2);

        init       = 1'b1;
        fifo_empty = 4'b1110;
        tick();
        chk("idle_init_prio", 32'(state), 32'd1);

        full_in    = 2'd1;
        empty_in   = 2'd2;
        init       = 1'b0;
        fifo_empty = 4'hF;
        tick();
        chk("thr_err_state", 32'(state), 32'd4);
        chk("thr_err_out", 32'(error_out), 32'd1);
        chk("thr_err_ufull", 32'(umbral_full), 32'd1);
        chk("thr_err_uempty", 32'(umbral_empty), 32'd2);

        init       = 1'b1;
        fifo_empty = 4'b0000;
        full_in    = 2'd3;
        empty_in   = 2'd0;
        tick();
        tick();
        chk("err_stuck", 32'(state), 32'd4);
        chk("err_pop", 32'(pop), 32'd0);
        chk("err_thr_hold", 32'(umbral_full), 32'd1);
        reset = 1'b1;
        #1;
        chk("err_reset_state", 32'(state), 32'd0);
        chk("err_reset_ufull", 32'(umbral_full), 32'd3);
        chk("err_reset_uempty", 32'(umbral_empty), 32'd1);

        go_active();
        chk("ga1_state", 32'(state), 32'd3);
        chk("ga1_pop", 32'(pop), 32'b0001);
        fifo_error = 4'b0010;
        #1;
        chk("fe_pop_same_cycle", 32'(pop), 32'b0001);
        tick();
        chk("fe_state", 32'(state), 32'd4);
        chk("fe_pop", 32'(pop), 32'd0);
        chk("fe_error_out", 32'(error_out), 32'd1);
        fifo_error = 4'b0000;

        reset = 1'b1;
        go_active();
        tick();
        chk("ga2_sel", 32'(sel), 32'd1);
        chk("ga2_pop", 32'(pop), 32'b0010);
        reset = 1'b1;
        #1;
        chk("async_pop", 32'(pop), 32'd0);
        chk("async_sel", 32'(sel), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_flags", 32'({idle_out, active_out, error_out}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_pop_sched.md
# fifo_pop_sched

Round-robin pop scheduler and configuration controller for the bank of 6-bit FIFOs. It sequences the FIFOs through reset, threshold configuration, idle and active phases, and drives the `buffer_full`/`buffer_empty` threshold inputs of every FIFO. In the active phase it grants one pop per cycle to a non-empty FIFO, rotating fairly. Granting stops while the downstream stage reports almost-full. It sits between the FIFO bank and the shared output path.

## Interface
- `NFIFO`, 4: number of FIFOs scheduled; must be a power of two.
- `THR_W`, 2: width of the threshold values.
- `FULL_DEF`, 3: reset value of `umbral_full`.
- `EMPTY_DEF`, 1: reset value of `umbral_empty`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: reset is asynchronous and active-high.
- `init` in 1: request configuration; thresholds are reloaded while the block is in INIT.
- `umbral_full_in` in THR_W: almost-full threshold to load.
- `umbral_empty_in` in THR_W: almost-empty threshold to load.
- `fifo_empty` in NFIFO: empty flag of each FIFO.
- `fifo_error` in NFIFO: error flag of each FIFO (push when full or pop when empty).
- `down_almost_full` in 1: downstream backpressure.
- `pop` out NFIFO: one-hot pop strobe, combinational.
- `sel` out log2(NFIFO): index of the FIFO being popped; 0 when `pop` is 0.
- `umbral_full` out THR_W: registered almost-full threshold, driven to all FIFOs.
- `umbral_empty` out THR_W: registered almost-empty threshold, driven to all FIFOs.
- `state` out 3: current state encoding.
- `idle_out` out 1: high when `state` is IDLE.
- `active_out` out 1: high when `state` is ACTIVE.
- `error_out` out 1: high when `state` is ERROR.

## Operation
- State encodings: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- While `reset` is high:
  - state = RESET; the RR pointer = 0.
  - `umbral_full` = FULL_DEF; `umbral_empty` = EMPTY_DEF.
  - `pop` = 0, `sel` = 0, `idle_out` = `active_out` = `error_out` = 0.
- RESET → INIT on the first edge after `reset` is released.
- INIT:
  - Every edge loads `umbral_full` ← `umbral_full_in` and `umbral_empty` ← `umbral_empty_in`.
  - When `init` is 0 the block leaves INIT on the same edge, still loading the thresholds.
  - Exit goes to IDLE if `umbral_full_in` > `umbral_empty_in` (unsigned compare); otherwise it goes to ERROR.
- IDLE:
  - `init` = 1 → INIT (takes priority).
  - Otherwise, any `fifo_empty` bit at 0 → ACTIVE.
- ACTIVE:
  - Grant goes to the first index i, scanning from the pointer upward modulo NFIFO, with `fifo_empty[i]` = 0.
  - `pop[i]` = 1 only when `down_almost_full` = 0.
  - On each cycle that pops, pointer ← (i+1) mod NFIFO. The pointer holds on cycles with no pop.
  - All FIFOs empty → IDLE on the next edge, with `pop` = 0 that cycle.
  - `init` is ignored while ACTIVE.
- ERROR:
  - Entered from any state except RESET when any `fifo_error` bit is 1; this has priority over every other transition.
  - `pop` = 0 while in ERROR.
  - ERROR is left only through `reset`.
  - Thresholds hold their values.

## Timing
- Pop decision has zero latency: `pop` and `sel` are combinational from the current state, pointer, `fifo_empty` and `down_almost_full`.
- A FIFO that is empty is never popped in that cycle.
- At most one `pop` bit is high per cycle.
- `down_almost_full` rising stalls pops in the same cycle. Pops resume in the first cycle it is 0.
- Simultaneous `fifo_error` and grant conditions: `pop` is still driven that cycle; state goes to ERROR on the next edge.
- Asserting `reset` mid-pop clears `pop` immediately (asynchronous clear).
- Threshold outputs change only on edges while in INIT, or on reset.
- Pointer wrap: after granting index NFIFO-1 the pointer returns to 0.

## Structure
- Shared package `fifo_sched_pkg` holds:
  - the state encodings;
  - the threshold defaults FULL_DEF=3, EMPTY_DEF=1;
  - the `THR_W` and `DATA_W`=6 constants used by the FIFO bank.
- One sub-module, `rr_arbiter`, takes request vector = ~`fifo_empty` and `enable`, and returns the one-hot grant and the next pointer. It has no state of its own; the pointer register stays in the top.
- The top contains the FSM, the threshold registers and the pointer register.

## Test plan
- Release reset with `init`=1, `umbral_full_in`=3, `umbral_empty_in`=1, then drop `init` → INIT for the held cycles, then IDLE; `umbral_full`=3, `umbral_empty`=1; `pop` stays 0.
- Hold `umbral_full_in`=1 and `umbral_empty_in`=2 when `init` drops → state=4, `error_out`=1; only `reset` returns the block to RESET.
- All four FIFOs non-empty with `down_almost_full`=0 → `sel` sequence 0,1,2,3,0 on consecutive cycles, with exactly one `pop` bit high each cycle.
- Only FIFO 2 is non-empty, pointer=3 → grant wraps to FIFO 2, `pop`=4'b0100, `sel`=2, next pointer=3. When FIFO 2 empties → IDLE on the next edge.
- Raise `down_almost_full` for 3 cycles mid-stream → `pop`=0 in those cycles, pointer unchanged; the grant order continues from where it stopped.
- Set `fifo_error[1]`=1 while ACTIVE → ERROR on the next edge, `pop`=0 afterwards. Assert `reset` mid-cycle → all outputs clear immediately.
